icache_responder: RTL and testbench
===================================

Name: icache_responder

Overview:
Direct-mapped instruction cache. It answers the fetch stage's read port (icache_addr / icache_re / icache_dout) and raises icache_stall on a miss. On a miss it refills one line from main memory over a valid/ready request channel and a multi-beat response channel. It sits between the fetch stage and the memory arbiter.

Parameters:
LINES, 64, number of cache lines; power of two, at least 2
WORDS, 4, 32-bit words per line; power of two, at least 2
NOP_INST, 32'h00000013, value driven on icache_dout when no read is outstanding

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
icache_addr  input  32  fetch byte address; bits [1:0] ignored
icache_re  input  1  read enable, sampled together with icache_addr
icache_dout  output  32  instruction for the previously sampled address
icache_stall  output  1  high while icache_dout is not yet valid; requester must hold addr/re
flush  input  1  invalidate all lines
mem_req_valid  output  1  line-fill request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  32  line-aligned address, low log2(WORDS)+2 bits zero
mem_resp_valid  input  1  one refill beat valid
mem_resp_data  input  32  refill word; beats arrive in ascending word order

Behaviour:
- Address split: offset = addr[log2(WORDS)+1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: data array LINES x WORDS x 32, tag array, valid bit-vector. No read-data reset is needed on the arrays; valid bits must be reset.
- Reset (async): valid bits all 0, state LOOKUP, addr_q = 0, re_q = 0, beat_cnt = 0.
- Reset outputs: icache_dout = NOP_INST, icache_stall = 0, mem_req_valid = 0, mem_req_addr = 0.
- Sampling: addr_q/re_q load icache_addr/icache_re on each edge where icache_stall == 0. They hold while stalled.
- Read latency is one cycle. Address is presented in cycle N; the result is in cycle N+1.
- State LOOKUP:
  - re_q == 0 -> dout = NOP_INST, stall = 0.
  - re_q == 1 and valid[index] and tag match -> hit: dout = data[index][offset], stall = 0 (combinational).
  - Miss -> stall = 1 in the same cycle; next state REQ.
- State REQ:
  - mem_req_valid = 1; mem_req_addr = addr_q with offset and byte bits cleared. Both are held stable until mem_req_ready.
  - On valid & ready -> REFILL, beat_cnt = 0. stall = 1.
- State REFILL:
  - Each mem_resp_valid writes mem_resp_data into data[index][beat_cnt], then beat_cnt increments.
  - On the beat where beat_cnt == WORDS-1: write tag, set valid[index], next state LOOKUP. stall = 1 throughout.
- After refill, LOOKUP re-checks addr_q, guarantees a hit, and deasserts stall.
- Miss penalty with ready and beats back-to-back: stall is high for WORDS+2 cycles.
- mem_resp_valid outside REFILL is ignored.
- flush: on the edge it is sampled, all valid bits clear.
  - If that same edge also sets valid for a completing refill, the refill wins for that line.
  - A flush during REQ/REFILL does not abort the fill.
  - A flush in a LOOKUP hit cycle does not change that cycle's output.
- Reset mid-REQ/REFILL abandons the fill immediately. The line stays invalid; the memory side must tolerate an abandoned request.
- Partial-beat state is never visible: a line is valid only after all WORDS beats.

Test Plan:
- Cold miss: reset, addr=0x0 re=1, ready=1, beats 0xA0..0xA3 back-to-back -> stall high 6 cycles, mem_req_addr=0x0, then dout=0xA0 with stall=0.
- Sequential hit: after the fill above, addr=0x4 then 0xC -> dout 0xA1 then 0xA3 each one cycle later, no stall, mem_req_valid stays 0.
- Conflict eviction: fill 0x0, then addr=0x400 (same index, LINES=64, WORDS=4) -> miss, mem_req_addr=0x400. Then addr=0x0 misses again.
- Backpressure: mem_req_ready low 3 cycles in REQ -> mem_req_valid=1 and mem_req_addr stable all 3 cycles. Beats with gaps -> stall held until the 4th beat.
- Flush: fill 0x0, pulse flush, read 0x0 -> miss and re-request of 0x0.
- Reset after 2 of 4 beats -> outputs return to reset values at once. Read 0x0 afterwards -> full miss, no stale hit.

Source files
------------

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache with single-line refill over a valid/ready request
// channel and an in-order multi-beat response channel.
//
// state     | meaning
// ST_LOOKUP | tag compare on addr_q; hit returns data, miss raises stall
// ST_REQ    | line-fill request presented and held until mem_req_ready
// ST_REFILL | collecting WORDS beats into the indexed line, then mark it valid
module icache_responder #(
  parameter int unsigned LINES    = 64,
  parameter int unsigned WORDS    = 4,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] icache_addr,
  input  logic        icache_re,
  output logic [31:0] icache_dout,
  output logic        icache_stall,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_LOOKUP = 2'd0,
    ST_REQ    = 2'd1,
    ST_REFILL = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic             re_q, re_d;
  logic [OFF_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [31:0]      data_q [LINES*WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];

  logic [OFF_W-1:0] offset;
  logic [IDX_W-1:0] index;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             data_we;
  logic             fill_done;
  logic             unused_byte_bits;

  assign offset = addr_q[OFF_W+1:2];
  assign index  = addr_q[OFF_W+2 +: IDX_W];
  assign tag    = addr_q[31 -: TAG_W];
  assign hit    = re_q && valid_q[index] && (tag_q[index] == tag);
  assign unused_byte_bits = ^addr_q[1:0];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_LOOKUP;
      addr_q     <= '0;
      re_q       <= 1'b0;
      beat_cnt_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      re_q       <= re_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
    end
  end

  // Line storage carries no reset; valid_q alone decides what is visible.
  always_ff @(posedge clk) begin
    if (data_we) begin
      data_q[{index, beat_cnt_q}] <= mem_resp_data;
    end
    if (fill_done) begin
      tag_q[index] <= tag;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = flush ? '0 : valid_q;
    data_we    = 1'b0;
    fill_done  = 1'b0;
    addr_d     = icache_stall ? addr_q : icache_addr;
    re_d       = icache_stall ? re_q : icache_re;
    case (state_q)
      ST_LOOKUP: begin
        if (re_q && !hit) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d    = ST_REFILL;
          beat_cnt_d = '0;
        end
      end
      ST_REFILL: begin
        if (mem_resp_valid) begin
          data_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + OFF_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            // Completing fill overrides a same-edge flush for this line.
            fill_done      = 1'b1;
            valid_d[index] = 1'b1;
            state_d        = ST_LOOKUP;
          end
        end
      end
      default: state_d = ST_LOOKUP;
    endcase
  end

  // Output logic
  always_comb begin
    icache_dout   = NOP_INST;
    icache_stall  = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_addr  = '0;
    case (state_q)
      ST_LOOKUP: begin
        if (re_q) begin
          if (hit) begin
            icache_dout = data_q[{index, offset}];
          end else begin
            icache_stall = 1'b1;
          end
        end
      end
      ST_REQ: begin
        icache_stall  = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
      end
      ST_REFILL: begin
        icache_stall = 1'b1;
      end
      default: begin
        icache_stall = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a line-level cache model.
module tb_icache_responder;

  localparam int          LINES = 64;
  localparam int          WORDS = 4;
  localparam logic [31:0] NOP   = 32'h00000013;
  localparam int          OFFB  = $clog2(WORDS) + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic        icache_stall;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;

  always #5 clk = ~clk;

  icache_responder #(.LINES(LINES), .WORDS(WORDS), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset),
    .icache_addr(icache_addr), .icache_re(icache_re),
    .icache_dout(icache_dout), .icache_stall(icache_stall),
    .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: cache contents as whole lines, plus progress of the outstanding miss.
  bit          m_valid [LINES];
  logic [31:0] m_line  [LINES];
  logic [31:0] m_data  [LINES][WORDS];
  logic [31:0] fbuf    [WORDS];
  logic [31:0] m_addr;
  bit          m_re, m_in_miss, m_req_out;
  int          m_beats;

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> OFFB) % LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_line[idx_of(a)] == (a >> OFFB));
  endfunction

  function automatic bit m_stall();
    return m_in_miss || (m_re && !m_hit(m_addr));
  endfunction

  always @(posedge clk or posedge reset) begin
    bit st, done;
    int ix;
    if (reset) begin
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      m_addr = '0; m_re = 1'b0; m_in_miss = 1'b0; m_req_out = 1'b0; m_beats = 0;
    end else begin
      st = m_stall();
      done = 1'b0;
      if (!m_in_miss) begin
        if (m_re && !m_hit(m_addr)) begin
          m_in_miss = 1'b1; m_req_out = 1'b1; m_beats = 0;
        end
      end else if (m_req_out) begin
        if (mem_req_ready) m_req_out = 1'b0;
      end else if (mem_resp_valid) begin
        fbuf[m_beats] = mem_resp_data;
        m_beats++;
        done = (m_beats == WORDS);
      end
      if (flush) foreach (m_valid[i]) m_valid[i] = 1'b0;
      if (done) begin
        ix = idx_of(m_addr);
        m_valid[ix] = 1'b1;
        m_line[ix]  = m_addr >> OFFB;
        for (int w = 0; w < WORDS; w++) m_data[ix][w] = fbuf[w];
        m_in_miss = 1'b0;
      end
      if (!st) begin
        m_addr = icache_addr;
        m_re   = icache_re;
      end
    end
  end

  always @(negedge clk) begin
    bit es;
    if (reset) begin
      chk("rst_dout", icache_dout, NOP);
      chk("rst_stall", 32'(icache_stall), 32'd0);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'd0);
    end else begin
      es = m_stall();
      chk("stall", 32'(icache_stall), 32'(es));
      chk("req_valid", 32'(mem_req_valid), 32'(m_req_out));
      if (m_req_out) chk("req_addr", mem_req_addr, (m_addr >> OFFB) << OFFB);
      if (!es) chk("dout", icache_dout,
                   m_re ? m_data[idx_of(m_addr)][int'((m_addr >> 2) % WORDS)] : NOP);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a read that must miss; serve the fill with optional ready delay and beat gaps.
  task automatic do_read(input string nm, input logic [31:0] a, input int rdy_dly,
                         input int gap, input logic [31:0] base, input int exp_stall);
    int req_cyc, b, g, sc;
    bit acc;
    icache_addr = a; icache_re = 1'b1;
    step();
    flush = 1'b0;
    req_cyc = 0; b = 0; g = 0; sc = 0; acc = 1'b0;
    for (int c = 0; c < 200 && icache_stall; c++) begin
      sc++;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      if (acc && b < WORDS) begin
        if (g >= gap) begin
          mem_resp_valid = 1'b1; mem_resp_data = base + 32'(b); b++; g = 0;
        end else g++;
      end
      if (mem_req_valid) begin
        req_cyc++;
        chk({nm, "_req_addr"}, mem_req_addr, (a >> OFFB) << OFFB);
        if (req_cyc > rdy_dly) begin
          mem_req_ready = 1'b1; acc = 1'b1;
        end
      end
      step();
    end
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    chk({nm, "_req_cycles"}, 32'(req_cyc), 32'(rdy_dly + 1));
    chk({nm, "_stall_cycles"}, 32'(sc), 32'(exp_stall));
    chk({nm, "_dout"}, icache_dout, base + ((a >> 2) % WORDS));
    chk({nm, "_stall_after"}, 32'(icache_stall), 32'd0);
  endtask

  task automatic hit_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
    icache_addr = a; icache_re = 1'b1;
    step();
    chk({nm, "_stall"}, 32'(icache_stall), 32'd0);
    chk({nm, "_dout"}, icache_dout, exp);
    chk({nm, "_req_valid"}, 32'(mem_req_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; icache_addr = '0; icache_re = 1'b0; flush = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    step(); step();
    chk("reset_dout", icache_dout, 32'h00000013);
    chk("reset_stall", 32'(icache_stall), 32'd0);
    chk("reset_req_addr", mem_req_addr, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_dout", icache_dout, 32'h00000013);

    do_read("cold", 32'h0, 0, 0, 32'hA0, 6);
    hit_read("seq_4", 32'h4, 32'hA1);
    hit_read("seq_c", 32'hC, 32'hA3);

    do_read("evict", 32'h400, 0, 0, 32'hB0, 6);
    do_read("backpressure", 32'h0, 3, 1, 32'hC0, 13);

    hit_read("pre_flush", 32'h8, 32'hC2);
    flush = 1'b1;
    #2;
    chk("flush_hit_dout", icache_dout, 32'hC2);
    chk("flush_hit_stall", 32'(icache_stall), 32'd0);
    do_read("flush_miss", 32'h0, 0, 0, 32'hF0, 6);

    icache_addr = 32'h800; icache_re = 1'b1;
    step();
    step();
    chk("abort_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hD0;
    step();
    mem_resp_data = 32'hD1;
    step();
    mem_resp_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_dout", icache_dout, 32'h00000013);
    chk("abort_stall", 32'(icache_stall), 32'd0);
    chk("abort_req_valid0", 32'(mem_req_valid), 32'd0);
    chk("abort_req_addr", mem_req_addr, 32'd0);
    step();
    reset = 1'b0;
    do_read("post_reset", 32'h0, 0, 0, 32'hE0, 6);

    for (int i = 0; i < 3000; i++) begin
      icache_addr = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
                  | 32'($urandom_range(0, 15));
      icache_re      = ($urandom_range(0, 9) < 8);
      mem_req_ready  = $urandom_range(0, 1) == 1;
      mem_resp_valid = ($urandom_range(0, 9) < 6);
      mem_resp_data  = $urandom;
      flush          = ($urandom_range(0, 99) < 3);
      reset          = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; flush = 1'b0; mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
